jump_sprite: RTL

JUMP_SPRITE -- requirements
Module: jump_sprite

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_physics.sv | 94 +++++++++
 rtl/jump_sprite.sv | 78 +++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the jumping sprite: visible-area porches, blank colour
// and the physics FSM state encoding.
package sprite_pkg;

   localparam int H_VIS_START = 144;
   localparam int H_VIS_END   = 784;
   localparam int V_VIS_START = 36;
   localparam int V_VIS_END   = 500;

   localparam logic [7:0] BLACK = 8'h00;

   typedef enum logic {
      GROUND = 1'b0,
      AIR    = 1'b1
   } state_t;

endpackage

// File: rtl/sprite_physics.sv
// Per-frame vertical motion of the sprite: launch, gravity with terminal
// velocity, landing on the floor and clamping at the ceiling.
module sprite_physics
   import sprite_pkg::*;
#(
   parameter int BOX_H    = 72,
   parameter int START_Y  = 200,
   parameter int JUMP_VEL = -12,
   parameter int GRAVITY  = 1,
   parameter int MAX_FALL = 15,
   parameter int VEL_W    = 8
) (
   input  logic       clk_25,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       jump,
   output logic [9:0] box_y,
   output logic       on_ground
);

   // 12 bits keeps box_y + vel from wrapping for any 10-bit position.
   localparam int YW = 12;

   state_t                   state_q, state_d;
   logic [9:0]               box_y_q, box_y_d;
   logic signed [VEL_W-1:0]  vel_q, vel_d;
   logic                     req_q, req_d;
   logic                     on_ground_q, on_ground_d;

   logic signed [YW-1:0]     y_cur, y_next, y_launch, vel_inc, vel_cap;

   always_comb begin
      y_cur    = {{(YW-10){1'b0}}, box_y_q};
      y_next   = y_cur + YW'(vel_q);
      y_launch = y_cur + YW'(JUMP_VEL);
      vel_inc  = YW'(vel_q) + YW'(GRAVITY);
      vel_cap  = (vel_inc > YW'(MAX_FALL)) ? YW'(MAX_FALL) : vel_inc;

      state_d = state_q;
      box_y_d = box_y_q;
      vel_d   = vel_q;
      req_d   = req_q;

      if (state_q == GROUND && jump) begin
         req_d = 1'b1;
      end

      if (tick) begin
         if (state_q == GROUND) begin
            // A jump seen in the tick cycle itself still counts for this frame.
            if (req_q || jump) begin
               box_y_d = y_launch[9:0];
               vel_d   = VEL_W'(JUMP_VEL + GRAVITY);
               state_d = AIR;
               req_d   = 1'b0;
            end
         end else begin
            if (y_next + YW'(BOX_H) >= YW'(V_VIS_END)) begin
               box_y_d = 10'(V_VIS_END - BOX_H);
               vel_d   = '0;
               state_d = GROUND;
            end else if (y_next < YW'(V_VIS_START)) begin
               box_y_d = 10'(V_VIS_START);
               vel_d   = '0;
            end else begin
               box_y_d = y_next[9:0];
               vel_d   = VEL_W'(vel_cap);
            end
         end
      end

      on_ground_d = (state_d == GROUND);
   end

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= AIR;
         box_y_q     <= 10'(START_Y);
         vel_q       <= '0;
         req_q       <= 1'b0;
         on_ground_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         box_y_q     <= box_y_d;
         vel_q       <= vel_d;
         req_q       <= req_d;
         on_ground_q <= on_ground_d;
      end
   end

   assign box_y     = box_y_q;
   assign on_ground = on_ground_q;

endmodule

// File: rtl/jump_sprite.sv
// Jumping square sprite: per-frame physics plus a registered pixel
// generator that paints the sprite inside the visible area.
module jump_sprite
   import sprite_pkg::*;
#(
   parameter int          BOX_W    = 72,
   parameter int          BOX_H    = 72,
   parameter int          START_X  = 400,
   parameter int          START_Y  = 200,
   parameter int          JUMP_VEL = -12,
   parameter int          GRAVITY  = 1,
   parameter int          MAX_FALL = 15,
   parameter logic [7:0]  COLOR    = 8'b111_000_11,
   parameter int          VEL_W    = 8
) (
   input  logic       clk_25,
   input  logic       rst_n,
   input  logic [9:0] h_count,
   input  logic [9:0] v_count,
   input  logic       jump,
   output logic [7:0] rgb,
   output logic [9:0] box_y,
   output logic       on_ground
);

   localparam logic [10:0] X_LO  = 11'(START_X);
   localparam logic [10:0] X_HI  = 11'(START_X + BOX_W);
   localparam logic [10:0] HV_LO = 11'(H_VIS_START);
   localparam logic [10:0] HV_HI = 11'(H_VIS_END);
   localparam logic [10:0] VV_LO = 11'(V_VIS_START);
   localparam logic [10:0] VV_HI = 11'(V_VIS_END);

   logic        tick;
   logic [10:0] h_ext, v_ext, y_lo, y_hi;
   logic        in_box;
   logic [7:0]  rgb_q, rgb_d;

   assign tick = (h_count == 10'd1) && (v_count == 10'd1);

   sprite_physics #(
      .BOX_H    (BOX_H),
      .START_Y  (START_Y),
      .JUMP_VEL (JUMP_VEL),
      .GRAVITY  (GRAVITY),
      .MAX_FALL (MAX_FALL),
      .VEL_W    (VEL_W)
   ) u_physics (
      .clk_25    (clk_25),
      .rst_n     (rst_n),
      .tick      (tick),
      .jump      (jump),
      .box_y     (box_y),
      .on_ground (on_ground)
   );

   always_comb begin
      h_ext  = {1'b0, h_count};
      v_ext  = {1'b0, v_count};
      y_lo   = {1'b0, box_y};
      y_hi   = {1'b0, box_y} + 11'(BOX_H);
      in_box = (h_ext >= X_LO)  && (h_ext < X_HI)  &&
               (v_ext >= y_lo)  && (v_ext < y_hi)  &&
               (h_ext >= HV_LO) && (h_ext < HV_HI) &&
               (v_ext >= VV_LO) && (v_ext < VV_HI);
      rgb_d  = in_box ? COLOR : BLACK;
   end

   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q <= BLACK;
      end else begin
         rgb_q <= rgb_d;
      end
   end

   assign rgb = rgb_q;

endmodule
